sprite_line_scheduler: RTL and testbench

//  Per-scanline sprite evaluation controller for the VGA sprite engine. On each line start it scans the

---
 rtl/sprite_line_scheduler_pkg.sv | 49 ++++
 rtl/sprite_line_scheduler_if.sv | 36 +++
 rtl/sprite_line_scheduler_hit_list.sv | 47 ++++
 rtl/sprite_line_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
// Holds the hit-test helpers so the scheduler and any standalone checks agree on them.
package sprite_sched_pkg;

  localparam int MAX_OBJECTS  = 20;
  localparam int MAX_PER_LINE = 8;
  localparam int SPRITE_H     = 16;
  localparam int VACTIVE      = 480;
  localparam int VTOTAL       = 525;

  localparam int IDX_W = $clog2(MAX_OBJECTS);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int PTR_W = $clog2(MAX_PER_LINE);
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam int Y_W   = 12;
  localparam int VC_W  = 10;

  typedef logic [IDX_W-1:0] obj_idx_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [VC_W-1:0]  line_t;
  typedef logic [Y_W-1:0]   obj_y_t;

  typedef struct packed {
    obj_idx_t idx;
    row_t     row;
  } hit_entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} sched_state_t;

  localparam line_t    LAST_LINE    = line_t'(VTOTAL - 1);
  localparam line_t    FIRST_HIDDEN = line_t'(VACTIVE);
  localparam obj_idx_t LAST_OBJ     = obj_idx_t'(MAX_OBJECTS - 1);

  // 13-bit compare: objects parked near y=4095 never wrap onto the top lines.
  function automatic logic obj_hit(line_t target, obj_y_t y, logic active);
    logic [Y_W:0] t13;
    logic [Y_W:0] y13;
    t13 = (Y_W+1)'(target);
    y13 = {1'b0, y};
    return active && (t13 >= y13) && (t13 < y13 + (Y_W+1)'(SPRITE_H));
  endfunction

  function automatic row_t obj_row(line_t target, obj_y_t y);
    return row_t'((Y_W+1)'(target) - {1'b0, y});
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Object-table read port plus the selected-object valid/ready stream toward the line-buffer fill engine.
interface sprite_line_scheduler_if;
  import sprite_sched_pkg::*;

  obj_idx_t obj_rd_idx;
  obj_y_t   obj_rd_y;
  logic     obj_rd_active;

  logic     sel_valid;
  logic     sel_ready;
  obj_idx_t sel_idx;
  row_t     sel_row;
  logic     sel_last;

  modport master (
    output obj_rd_idx,
    input  obj_rd_y,
    input  obj_rd_active,
    output sel_valid,
    input  sel_ready,
    output sel_idx,
    output sel_row,
    output sel_last
  );

  modport slave (
    input  obj_rd_idx,
    output obj_rd_y,
    output obj_rd_active,
    input  sel_valid,
    output sel_ready,
    input  sel_idx,
    input  sel_row,
    input  sel_last
  );
endinterface

// File: rtl/sprite_line_scheduler_hit_list.sv
// Per-line list of selected objects in priority order; pushes beyond capacity are ignored.
// Random-access read so the scheduler can preload the next entry while one is on the bus.
module sprite_hit_list
  import sprite_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  hit_entry_t push_entry,
  input  ptr_t       rd_ptr,
  output hit_entry_t rd_entry,
  output cnt_t       count,
  output logic       full
);

  hit_entry_t entries_q [MAX_PER_LINE];
  hit_entry_t entries_d [MAX_PER_LINE];
  cnt_t       count_q;
  cnt_t       count_d;

  assign full     = (count_q == cnt_t'(MAX_PER_LINE));
  assign count    = count_q;
  assign rd_entry = entries_q[rd_ptr];

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push && !full) begin
      entries_d[count_q[PTR_W-1:0]] = push_entry;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans the object table for sprites on the next display line and streams the hits to the fill engine.
// Also owns the ping-pong line-buffer bank select.
//
//  state | meaning
//  IDLE  | out of reset, waiting for the first line_start
//  SCAN  | reading obj 0..MAX_OBJECTS-1, hit test one cycle behind the read
//  EMIT  | presenting hit-list entries over sel_valid/sel_ready
//  DONE  | line complete (or target in vblank), waiting for line_start
module sprite_line_scheduler
  import sprite_sched_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           line_start,
  input  line_t                          vcount,
  sprite_line_scheduler_if.master        obj_sel,
  output logic                           line_done,
  output logic                           overflow,
  output logic                           aborted,
  output logic                           buf_sel
);

  sched_state_t state_q, state_d;
  line_t        target_q, target_d;
  obj_idx_t     rd_idx_q, rd_idx_d;
  obj_idx_t     chk_idx_q, chk_idx_d;
  logic         rd_done_q, rd_done_d;
  logic         data_vld_q, data_vld_d;
  ptr_t         ptr_q, ptr_d;
  logic         sel_valid_q, sel_valid_d;
  obj_idx_t     sel_idx_q, sel_idx_d;
  row_t         sel_row_q, sel_row_d;
  logic         sel_last_q, sel_last_d;
  logic         line_done_q, line_done_d;
  logic         overflow_q, overflow_d;
  logic         aborted_q, aborted_d;
  logic         buf_sel_q, buf_sel_d;

  line_t        new_target;
  logic         hit_now;
  row_t         hit_row;
  hit_entry_t   push_entry;
  hit_entry_t   list_entry;
  ptr_t         list_rd_ptr;
  cnt_t         hit_count;
  cnt_t         hit_total;
  logic         hit_full;

  assign new_target = (vcount == LAST_LINE) ? '0 : vcount + 1'b1;
  assign hit_now    = (state_q == SCAN) && data_vld_q &&
                      obj_hit(target_q, obj_sel.obj_rd_y, obj_sel.obj_rd_active);
  assign hit_row    = obj_row(target_q, obj_sel.obj_rd_y);
  assign push_entry = '{idx: chk_idx_q, row: hit_row};
  // In SCAN the list head is needed for the first emit; in EMIT preload the entry after the current one.
  assign list_rd_ptr = (state_q == EMIT) ? ptr_q + 1'b1 : '0;
  assign hit_total   = hit_count + cnt_t'(hit_now && !hit_full);

  sprite_hit_list u_hit_list (
    .clk        (clk),
    .reset      (reset),
    .clear      (line_start),
    .push       (hit_now),
    .push_entry (push_entry),
    .rd_ptr     (list_rd_ptr),
    .rd_entry   (list_entry),
    .count      (hit_count),
    .full       (hit_full)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    rd_idx_d    = rd_idx_q;
    chk_idx_d   = chk_idx_q;
    rd_done_d   = rd_done_q;
    data_vld_d  = data_vld_q;
    ptr_d       = ptr_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    sel_row_d   = sel_row_q;
    sel_last_d  = sel_last_q;
    line_done_d = 1'b0;
    overflow_d  = overflow_q;
    aborted_d   = 1'b0;
    buf_sel_d   = buf_sel_q;

    if (line_start) begin
      aborted_d   = (state_q == SCAN) || (state_q == EMIT);
      buf_sel_d   = ~buf_sel_q;
      overflow_d  = 1'b0;
      target_d    = new_target;
      rd_idx_d    = '0;
      rd_done_d   = 1'b0;
      data_vld_d  = 1'b0;
      ptr_d       = '0;
      sel_valid_d = 1'b0;
      sel_last_d  = 1'b0;
      if (new_target >= FIRST_HIDDEN) begin
        state_d     = DONE;
        line_done_d = 1'b1;
      end else begin
        state_d = SCAN;
      end
    end else begin
      case (state_q)
        SCAN: begin
          if (hit_now && hit_full) overflow_d = 1'b1;
          if (!rd_done_q) begin
            data_vld_d = 1'b1;
            chk_idx_d  = rd_idx_q;
            if (rd_idx_q == LAST_OBJ) rd_done_d = 1'b1;
            else                      rd_idx_d  = rd_idx_q + 1'b1;
          end else begin
            // Final read result is being tested this cycle; it may be the only hit.
            data_vld_d = 1'b0;
            if (hit_total == '0) begin
              state_d     = DONE;
              line_done_d = 1'b1;
            end else begin
              state_d     = EMIT;
              sel_valid_d = 1'b1;
              ptr_d       = '0;
              sel_last_d  = (hit_total == cnt_t'(1));
              if (hit_count == '0) begin
                sel_idx_d = chk_idx_q;
                sel_row_d = hit_row;
              end else begin
                sel_idx_d = list_entry.idx;
                sel_row_d = list_entry.row;
              end
            end
          end
        end
        EMIT: begin
          if (sel_valid_q && obj_sel.sel_ready) begin
            if (sel_last_q) begin
              state_d     = DONE;
              sel_valid_d = 1'b0;
              sel_last_d  = 1'b0;
              line_done_d = 1'b1;
            end else begin
              ptr_d      = ptr_q + 1'b1;
              sel_idx_d  = list_entry.idx;
              sel_row_d  = list_entry.row;
              sel_last_d = ((cnt_t'(ptr_q) + cnt_t'(2)) == hit_count);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      rd_idx_q    <= '0;
      chk_idx_q   <= '0;
      rd_done_q   <= 1'b0;
      data_vld_q  <= 1'b0;
      ptr_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      sel_row_q   <= '0;
      sel_last_q  <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      aborted_q   <= 1'b0;
      buf_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      rd_idx_q    <= rd_idx_d;
      chk_idx_q   <= chk_idx_d;
      rd_done_q   <= rd_done_d;
      data_vld_q  <= data_vld_d;
      ptr_q       <= ptr_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      sel_row_q   <= sel_row_d;
      sel_last_q  <= sel_last_d;
      line_done_q <= line_done_d;
      overflow_q  <= overflow_d;
      aborted_q   <= aborted_d;
      buf_sel_q   <= buf_sel_d;
    end
  end

  assign obj_sel.obj_rd_idx = rd_idx_q;
  assign obj_sel.sel_valid  = sel_valid_q;
  assign obj_sel.sel_idx    = sel_idx_q;
  assign obj_sel.sel_row    = sel_row_q;
  assign obj_sel.sel_last   = sel_last_q;
  assign line_done          = line_done_q;
  assign overflow           = overflow_q;
  assign aborted            = aborted_q;
  assign buf_sel            = buf_sel_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: table of scanline vectors, reference hit list queued per line_start,
// entries popped and compared on each sel_valid/sel_ready transfer; hand sequences for abort and reset.
module tb_sprite_line_scheduler;
  import sprite_sched_pkg::*;

  typedef struct {
    int   idx;
    int   row;
    logic last;
  } exp_t;

  typedef struct {
    logic [9:0]        vc;
    logic [19:0]       act;
    logic [19:0][11:0] ys;
    int                exp_n;
    logic              exp_ovf;
    int                mode;
    logic              hidden;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       line_start;
  logic [9:0] vcount;
  logic       line_done, overflow, aborted, buf_sel;

  sprite_line_scheduler_if bus ();

  sprite_line_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .vcount     (vcount),
    .obj_sel    (bus),
    .line_done  (line_done),
    .overflow   (overflow),
    .aborted    (aborted),
    .buf_sel    (buf_sel)
  );

  logic [11:0] mem_y   [32];
  logic        mem_act [32];

  always @(posedge clk) begin
    bus.obj_rd_y      <= mem_y[bus.obj_rd_idx];
    bus.obj_rd_active <= mem_act[bus.obj_rd_idx];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q [$];
  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_buf = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(logic [9:0] vc, logic [19:0] act, logic [11:0] yall,
                              int n, logic ovf, int mode, logic hidden);
    vec_t v;
    v.vc = vc; v.act = act; v.exp_n = n; v.exp_ovf = ovf; v.mode = mode; v.hidden = hidden;
    for (int i = 0; i < 20; i++) v.ys[i] = yall;
    return v;
  endfunction

  // Straightforward reference: scan the table in index order, keep the first 8 hits.
  function automatic void ref_fill(input logic [9:0] vc);
    int   tgt;
    int   n;
    int   k;
    exp_t e;
    tgt = (vc == 10'd524) ? 0 : int'(vc) + 1;
    n = 0;
    k = 0;
    if (tgt >= 480) return;
    for (int i = 0; i < 20; i++)
      if (mem_act[i] && tgt >= int'(mem_y[i]) && tgt < int'(mem_y[i]) + 16) n++;
    if (n > 8) n = 8;
    for (int i = 0; i < 20 && k < n; i++) begin
      if (mem_act[i] && tgt >= int'(mem_y[i]) && tgt < int'(mem_y[i]) + 16) begin
        e.idx = i; e.row = tgt - int'(mem_y[i]); e.last = (k == n - 1);
        exp_q.push_back(e);
        k++;
      end
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin mem_y[i] = '0; mem_act[i] = 1'b0; end
  endtask

  task automatic load_vec(input vec_t v);
    clear_mem();
    for (int i = 0; i < 20; i++) begin mem_y[i] = v.ys[i]; mem_act[i] = v.act[i]; end
  endtask

  task automatic start_line(input logic [9:0] vc);
    vcount = vc;
    line_start = 1'b1;
    exp_buf = ~exp_buf;
    exp_q.delete();
    ref_fill(vc);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_extra: got entry idx %0d, expected no entry", tag, int'(bus.sel_idx));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_idx"},  int'(bus.sel_idx),  e.idx);
      check({tag, "_row"},  int'(bus.sel_row),  e.row);
      check({tag, "_last"}, int'(bus.sel_last), int'(e.last));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_idx"},    int'(bus.obj_rd_idx), 0);
    check({tag, "_sel_valid"}, int'(bus.sel_valid),  0);
    check({tag, "_sel_idx"},   int'(bus.sel_idx),    0);
    check({tag, "_sel_row"},   int'(bus.sel_row),    0);
    check({tag, "_sel_last"},  int'(bus.sel_last),   0);
    check({tag, "_line_done"}, int'(line_done),      0);
    check({tag, "_overflow"},  int'(overflow),       0);
    check({tag, "_aborted"},   int'(aborted),        0);
    check({tag, "_buf_sel"},   int'(buf_sel),        0);
  endtask

  // Runs from the cycle after line_start until line_done; mode 0 ready=1, 1 random, 2 ten-low-then-pulse.
  task automatic monitor_line(input int n_exp, input logic ovf_exp, input int mode,
                              input logic hidden, input logic abort_exp, input string tag);
    int   got = 0, first_v = -1, done_cyc = -1, max_idx = 0, wait_cnt = 0, stray = 0;
    logic hold = 1'b0, r;
    int   h_idx = 0, h_row = 0, h_last = 0;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        line_start = 1'b0;
        check({tag, "_buf_sel"},   int'(buf_sel),       int'(exp_buf));
        check({tag, "_ovf_clr"},   int'(overflow),      0);
        check({tag, "_aborted"},   int'(aborted),       int'(abort_exp));
        check({tag, "_valid_c1"},  int'(bus.sel_valid), 0);
      end else if (aborted) begin
        stray++;
      end
      if (int'(bus.obj_rd_idx) > max_idx) max_idx = int'(bus.obj_rd_idx);
      if (hold) begin
        check({tag, "_hold_v"},   int'(bus.sel_valid), 1);
        check({tag, "_hold_idx"}, int'(bus.sel_idx),   h_idx);
        check({tag, "_hold_row"}, int'(bus.sel_row),   h_row);
        check({tag, "_hold_lst"}, int'(bus.sel_last),  h_last);
      end
      if (bus.sel_valid && first_v < 0) first_v = cyc;
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (wait_cnt == 10);
      endcase
      bus.sel_ready = r;
      hold = bus.sel_valid && !r;
      h_idx = int'(bus.sel_idx); h_row = int'(bus.sel_row); h_last = int'(bus.sel_last);
      if (bus.sel_valid && !r) wait_cnt++;
      if (bus.sel_valid && r) begin
        pop_check(tag);
        got++;
        wait_cnt = 0;
      end
      if (line_done) done_cyc = cyc;
    end
    bus.sel_ready = 1'b0;
    check({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    check({tag, "_count"},     got, n_exp);
    check({tag, "_q_left"},    exp_q.size(), 0);
    check({tag, "_overflow"},  int'(overflow), int'(ovf_exp));
    check({tag, "_stray_ab"},  stray, 0);
    if (hidden) begin
      check({tag, "_done_lat"}, done_cyc, 1);
      check({tag, "_no_reads"}, max_idx, 0);
    end else begin
      check({tag, "_max_rd"}, max_idx, 19);
      if (n_exp == 0) check({tag, "_done_lat"}, done_cyc, 22);
      else            check({tag, "_first_v"},  first_v, 22);
    end
  endtask

  task automatic run_vec(input int k);
    load_vec(vecs[k]);
    start_line(vecs[k].vc);
    monitor_line(vecs[k].exp_n, vecs[k].exp_ovf, vecs[k].mode, vecs[k].hidden, 1'b0,
                 $sformatf("v%0d", k));
  endtask

  task automatic abort_seq();
    int c;
    clear_mem();
    for (int i = 0; i < 5; i++) begin mem_y[i] = 12'd100; mem_act[i] = 1'b1; end
    mem_y[10] = 12'd300; mem_act[10] = 1'b1;
    mem_y[11] = 12'd300; mem_act[11] = 1'b1;
    start_line(10'd99);
    @(negedge clk);
    line_start = 1'b0;
    c = 0;
    while (!bus.sel_valid && c < 40) begin @(negedge clk); c++; end
    check("abort_first_v", int'(bus.sel_valid), 1);
    bus.sel_ready = 1'b1;
    pop_check("abort_pre0");
    @(negedge clk);
    check("abort_second_v", int'(bus.sel_valid), 1);
    pop_check("abort_pre1");
    start_line(10'd305);
    monitor_line(2, 1'b0, 0, 1'b0, 1'b1, "abort");
  endtask

  task automatic reset_seq();
    int c;
    clear_mem();
    for (int i = 0; i < 3; i++) begin mem_y[i] = 12'd100; mem_act[i] = 1'b1; end
    start_line(10'd99);
    @(negedge clk);
    line_start = 1'b0;
    bus.sel_ready = 1'b0;
    c = 0;
    while (!bus.sel_valid && c < 40) begin @(negedge clk); c++; end
    check("rst_pre_valid", int'(bus.sel_valid), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_async");
    @(negedge clk);
    reset = 1'b0;
    exp_buf = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    line_start = 1'b1;
    vcount = 10'd99;
    @(negedge clk);
    check_reset_vals("rst_coinc");
    reset = 1'b0;
    line_start = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    line_start = 1'b0;
    vcount = '0;
    bus.sel_ready = 1'b0;
    clear_mem();

    vecs[0] = mk(10'd99,  20'h00004, 12'd100, 1, 1'b0, 0, 1'b0);
    vecs[1] = mk(10'd99,  20'h00007, 12'd0,   2, 1'b0, 2, 1'b0);
    vecs[1].ys[0] = 12'd95; vecs[1].ys[1] = 12'd90; vecs[1].ys[2] = 12'd200;
    vecs[2] = mk(10'd55,  20'h003FF, 12'd50,  8, 1'b1, 1, 1'b0);
    vecs[3] = mk(10'd10,  20'hFFFFF, 12'd300, 0, 1'b0, 0, 1'b0);
    vecs[4] = mk(10'd479, 20'hFFFFF, 12'd480, 0, 1'b0, 0, 1'b1);
    vecs[5] = mk(10'd524, 20'h00003, 12'd0,   1, 1'b0, 0, 1'b0);
    vecs[5].ys[1] = 12'd4090;
    vecs[6] = mk(10'd99,  20'h80078, 12'd0,   3, 1'b0, 1, 1'b0);
    vecs[6].ys[3] = 12'd85; vecs[6].ys[4] = 12'd84; vecs[6].ys[5] = 12'd100;
    vecs[6].ys[6] = 12'd101; vecs[6].ys[19] = 12'd100;
    vecs[7] = mk(10'd204, 20'hFF000, 12'd200, 8, 1'b0, 1, 1'b0);

    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_rel");

    for (int k = 0; k < 8; k++) run_vec(k);

    abort_seq();
    reset_seq();
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
